sawtooth_phase_counter: RTL and testbench

//  Programmable phase accumulator: the sawtooth source directly upstream of the triangle stage.

---
 rtl/wave_pkg.sv | 12 +
 rtl/strobe_divider.sv | 38 +++
 rtl/sawtooth_phase_counter.sv | 115 +++++++++++
 tb/tb_sawtooth_phase_counter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// Shared definitions for the waveform-generation blocks: FSM state
// encodings and default datapath widths.
package wave_pkg;

    localparam int DEF_N_FRAC = 7;
    localparam int DEF_N_ACC  = 16;
    localparam int DEF_N_DIV  = 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/strobe_divider.sv
// Prescaler producing one step pulse every max(prescale,1)+1 cycles
// while running. The period never drops below 2, so the downstream
// consumer always gets a cycle to sample the value after a strobe.
module strobe_divider
    import wave_pkg::*;
#(
    parameter int N_DIV = DEF_N_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             run,
    input  logic             clear,
    input  logic [N_DIV-1:0] prescale,
    output logic             step
);

    logic [N_DIV-1:0] div_cnt;
    logic [N_DIV-1:0] p_eff;

    assign p_eff = (prescale == '0) ? {{(N_DIV-1){1'b0}}, 1'b1} : prescale;

    // >= rather than == so that lowering prescale below the running count
    // forces a step on the next edge instead of waiting for a counter wrap.
    assign step = run && !clear && (div_cnt >= p_eff);

    // Count up while running; restart on clear, on entry to run, and on each step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (clear || start || step) begin
            div_cnt <= '0;
        end else if (run) begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sawtooth_phase_counter.sv
// Programmable phase accumulator feeding the triangle stage. Emits the top
// N_FRAC+1 accumulator bits as a signed sawtooth sample with a one-cycle
// strobe at the prescaled rate. New frequency words are held in a shadow
// register and only take effect at an accumulator wrap.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | enable low: prescaler, accumulator and outputs hold
//  RUN     | enable high: accumulator steps on every prescaler pulse
module sawtooth_phase_counter
    import wave_pkg::*;
#(
    parameter int N_FRAC     = DEF_N_FRAC,
    parameter int N_ACC      = DEF_N_ACC,
    parameter int N_DIV      = DEF_N_DIV,
    parameter int RESET_WORD = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              clear_i,
    input  logic [N_DIV-1:0]  prescale_i,
    input  logic [N_ACC-1:0]  freq_word_i,
    input  logic              freq_word_valid_i,
    output logic              freq_word_ready_o,
    output logic [N_FRAC:0]   counter_value_o,
    output logic              next_counter_value_strobe_o,
    output logic              wrap_o
);

    logic [0:0]       state;
    logic [N_ACC-1:0] acc;
    logic [N_ACC-1:0] active_word;
    logic [N_ACC-1:0] shadow_word;
    logic             pending;
    logic [N_ACC:0]   sum;
    logic             step;
    logic             start;
    logic             run;
    logic             carry;
    logic             apply_word;
    logic             take_word;

    assign start = (state == ST_IDLE) && enable_i && !clear_i;
    assign run   = (state == ST_RUN) && enable_i;

    assign sum   = {1'b0, acc} + {1'b0, active_word};
    assign carry = sum[N_ACC];

    // In IDLE no step can be in flight, so a pending word is safe to apply at once.
    assign apply_word = pending && ((step && carry) || ((state == ST_IDLE) && !clear_i));
    assign take_word  = freq_word_valid_i && !pending;

    assign freq_word_ready_o = ~pending;

    strobe_divider #(
        .N_DIV (N_DIV)
    ) u_div (
        .clk      (clk_i),
        .rst      (rst_i),
        .start    (start),
        .run      (run),
        .clear    (clear_i),
        .prescale (prescale_i),
        .step     (step)
    );

    // Run/idle follows enable; clear freezes the state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else if (!clear_i) begin
            state <= enable_i ? ST_RUN : ST_IDLE;
        end
    end

    // Accumulator and registered outputs; clear beats a coincident step.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc                         <= '0;
            counter_value_o             <= '0;
            next_counter_value_strobe_o <= 1'b0;
            wrap_o                      <= 1'b0;
        end else if (clear_i) begin
            acc                         <= '0;
            counter_value_o             <= '0;
            next_counter_value_strobe_o <= 1'b0;
            wrap_o                      <= 1'b0;
        end else if (step) begin
            acc                         <= sum[N_ACC-1:0];
            counter_value_o             <= sum[N_ACC-1 -: N_FRAC+1];
            next_counter_value_strobe_o <= 1'b1;
            wrap_o                      <= carry;
        end else begin
            next_counter_value_strobe_o <= 1'b0;
            wrap_o                      <= 1'b0;
        end
    end

    // Shadow/pending handshake; apply and accept are exclusive since accept needs pending=0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active_word <= N_ACC'(RESET_WORD);
            shadow_word <= '0;
            pending     <= 1'b0;
        end else if (apply_word) begin
            active_word <= shadow_word;
            pending     <= 1'b0;
        end else if (take_word) begin
            shadow_word <= freq_word_i;
            pending     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sawtooth_phase_counter.sv
// Self-checking bench for sawtooth_phase_counter: directed scenarios with
// literal expectations followed by a randomized run, all outputs compared
// every cycle against an arithmetic reference model.
module tb_sawtooth_phase_counter;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        clear;
    logic [7:0]  prescale;
    logic [15:0] freq_word;
    logic        freq_word_valid;
    logic        freq_word_ready;
    logic [7:0]  counter_value;
    logic        strobe;
    logic        wrap;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    sawtooth_phase_counter dut (
        .clk_i                       (clk),
        .rst_i                       (rst),
        .enable_i                    (enable),
        .clear_i                     (clear),
        .prescale_i                  (prescale),
        .freq_word_i                 (freq_word),
        .freq_word_valid_i           (freq_word_valid),
        .freq_word_ready_o           (freq_word_ready),
        .counter_value_o             (counter_value),
        .next_counter_value_strobe_o (strobe),
        .wrap_o                      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic int sval(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    // Reference model: phase as an integer in [0, 65536), output is phase/256 read as signed.
    int m_phase, m_word, m_shadow, m_cnt, m_val, m_p, m_sum;
    bit m_run, m_pend, m_strobe, m_wrap, m_take;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_word = 256; m_shadow = 0; m_pend = 0;
            m_cnt = 0; m_val = 0; m_strobe = 0; m_wrap = 0; m_run = 0;
        end else begin
            m_take   = freq_word_valid && !m_pend;
            m_strobe = 0;
            m_wrap   = 0;
            if (clear) begin
                m_phase = 0; m_cnt = 0; m_val = 0;
            end else if (!m_run) begin
                if (m_pend) begin m_word = m_shadow; m_pend = 0; end
                if (enable) begin m_run = 1; m_cnt = 0; end
            end else if (!enable) begin
                m_run = 0;
            end else begin
                m_p = (int'(prescale) < 1) ? 1 : int'(prescale);
                if (m_cnt >= m_p) begin
                    m_sum   = m_phase + m_word;
                    m_wrap  = (m_sum >= 65536);
                    m_phase = m_sum % 65536;
                    m_val   = m_phase / 256;
                    if (m_val >= 128) m_val -= 256;
                    m_strobe = 1;
                    m_cnt    = 0;
                    if (m_wrap && m_pend) begin m_word = m_shadow; m_pend = 0; end
                end else begin
                    m_cnt++;
                end
            end
            if (m_take) begin m_shadow = int'(freq_word); m_pend = 1; end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("model_value",  sval(counter_value), m_val);
            chk("model_strobe", int'(strobe), int'(m_strobe));
            chk("model_wrap",   int'(wrap), int'(m_wrap));
            chk("model_ready",  int'(freq_word_ready), int'(!m_pend));
        end
    end

    task automatic wait_strobe(output int c, output int v, output int w);
        c = -1; v = 0; w = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (strobe) begin
                c = cyc; v = sval(counter_value); w = int'(wrap);
                return;
            end
        end
        n_total++;
        $display("FAIL strobe_timeout: no strobe within 600 cycles (cycle %0d)", cyc);
    endtask

    int c, v, w, prev_c, en_edge, held, exp_v;

    initial begin
        rst = 1'b1; enable = 1'b0; clear = 1'b0; prescale = 8'd0;
        freq_word = '0; freq_word_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset word 256 advances the output by 1 per step.
        prescale = 8'd1; enable = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            wait_strobe(c, v, w);
            chk("reset_word_step", v, k);
        end

        // Asynchronous reset between edges.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_value",  int'(counter_value), 0);
        chk("async_rst_strobe", int'(strobe), 0);
        chk("async_rst_wrap",   int'(wrap), 0);
        chk("async_rst_ready",  int'(freq_word_ready), 1);
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Load 0x1000 while idle, then run with prescale 3.
        freq_word = 16'h1000; freq_word_valid = 1'b1;
        @(negedge clk);
        freq_word_valid = 1'b0;
        @(negedge clk);
        prescale = 8'd3; enable = 1'b1;
        en_edge = cyc + 1;
        prev_c = en_edge;
        for (int k = 1; k <= 16; k++) begin
            wait_strobe(c, v, w);
            exp_v = (k * 16) % 256;
            if (exp_v >= 128) exp_v -= 256;
            chk("ramp_value", v, exp_v);
            chk("ramp_wrap", w, (k == 16) ? 1 : 0);
            chk("ramp_spacing", c - prev_c, (k == 1) ? 4 : 4);
            prev_c = c;
        end

        // New word mid-period; second word stalls until the first is applied.
        freq_word = 16'h2000; freq_word_valid = 1'b1;
        @(negedge clk);
        chk("ready_after_xfer", int'(freq_word_ready), 0);
        freq_word = 16'h0800;
        for (int k = 1; k <= 16; k++) begin
            wait_strobe(c, v, w);
            exp_v = (k * 16) % 256;
            if (exp_v >= 128) exp_v -= 256;
            chk("old_word_value", v, exp_v);
            if (k < 16) chk("stall_ready", int'(freq_word_ready), 0);
        end
        chk("ready_after_wrap", int'(freq_word_ready), 1);
        @(negedge clk);
        chk("second_word_taken", int'(freq_word_ready), 0);
        freq_word_valid = 1'b0;
        wait_strobe(c, v, w);
        chk("new_word_first_step", v, 32);

        // Hold for 10 cycles, then re-enable.
        enable = 1'b0;
        @(negedge clk);
        held = sval(counter_value);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_strobe", int'(strobe), 0);
            chk("hold_value", sval(counter_value), held);
        end
        enable = 1'b1;
        en_edge = cyc + 1;
        wait_strobe(c, v, w);
        chk("reenable_latency", c - en_edge, 4);

        // Minimum period with prescale 0 and 1.
        prescale = 8'd0;
        wait_strobe(c, v, w);
        wait_strobe(prev_c, v, w);
        wait_strobe(c, v, w);
        chk("p0_spacing", c - prev_c, 2);
        prescale = 8'd1;
        wait_strobe(prev_c, v, w);
        wait_strobe(c, v, w);
        chk("p1_spacing", c - prev_c, 2);

        // Clear landing on a step edge.
        prescale = 8'd3;
        wait_strobe(c, v, w);
        wait_strobe(c, v, w);
        repeat (3) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        chk("clear_value", int'(counter_value), 0);
        chk("clear_strobe", int'(strobe), 0);
        clear = 1'b0;

        // Randomized run.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 799) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            enable          = ($urandom_range(0, 9) != 0);
            clear           = ($urandom_range(0, 49) == 0);
            prescale        = 8'($urandom_range(0, 5));
            freq_word_valid = ($urandom_range(0, 2) == 0);
            freq_word       = 16'($urandom);
        end
        enable = 1'b0; clear = 1'b0; freq_word_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
